// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM answering the core's load/store
// strobes. An accepted access holds stall for WAIT_CYCLES+1 cycles. Stores
// commit in the response cycle. Loads return sign- or zero-extended data one
// cycle after stall drops. Misaligned, illegal-width or out-of-range
// requests are not performed; they raise a one-cycle acc_err pulse instead.
//
// Ports:
//   clk      core clock
//   rst_n    asynchronous active-low reset
//   memr     load request, held by the core until stall is low
//   memw     store request, held by the core until stall is low (wins over memr)
//   funct3   width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr     byte address
//   wdata    store data (low bits used for B/H)
//   stall    high while an accepted access is not yet complete
//   rdata    extended load data, holds until the next load completes
//   rvalid   one-cycle pulse when rdata carries fresh load data
//   acc_err  one-cycle pulse after a rejected request
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memr,
  input  logic        memw,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        acc_err
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L   = 32'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("dmem_responder: WAIT_CYCLES must be in 0..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t state;
  logic [3:0] cnt;
  logic       is_store_p0;

  // Latched request (data only, never reset)
  logic [AW+1:0] addr_p0;
  logic [31:0]   wdata_p0;
  logic [2:0]    funct3_p0;

  logic [31:0] mem [DEPTH_WORDS];

  logic        req;
  logic        f3_ok;
  logic        align_ok;
  logic        range_ok;
  logic        legal;
  logic        accept;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic [31:0] word_rd;

  // Extracts the addressed byte/half from a word and extends it per funct3.
  function automatic logic [31:0] load_ext(input logic [31:0] word,
                                           input logic [1:0]  off,
                                           input logic [2:0]  f3);
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic [31:0]        r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h  = off[1] ? word[31:16] : word[15:0];
    sb = $signed(b);
    sh = $signed(h);
    case (f3)
      3'b000:  r = 32'(sb);
      3'b001:  r = 32'(sh);
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign req = memr | memw;

  // Legality is judged against the effective access type (store wins).
  always_comb begin
    if (memw) f3_ok = funct3 inside {3'b000, 3'b001, 3'b010};
    else      f3_ok = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (funct3[1:0])
      2'b01:   align_ok = ~addr[0];
      2'b10:   align_ok = (addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    range_ok = ({2'b00, addr[31:2]} < DEPTH_L);
    legal    = f3_ok & align_ok & range_ok;
  end

  assign accept = (state == ST_IDLE) & req & legal;

  // Stall rises in the accepting cycle itself so the core holds the request;
  // it is forced low while reset is asserted.
  assign stall = rst_n & (accept | (state == ST_WAIT));

  // Stage p0: capture the accepted request
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0   <= addr[AW+1:0];
      wdata_p0  <= wdata;
      funct3_p0 <= funct3;
    end
  end

  // Byte-lane enables and lane-replicated store data
  always_comb begin
    case (funct3_p0[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_p0[1:0];
        wlane = {4{wdata_p0[7:0]}};
      end
      2'b01: begin
        be    = addr_p0[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_p0[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata_p0;
      end
    endcase
  end

  assign word_rd = mem[addr_p0[AW+1:2]];

  // Stage p1: commit store in the response cycle. State is reset
  // asynchronously, so a reset during an access suppresses the write.
  always_ff @(posedge clk) begin
    if (state == ST_RESP && is_store_p0) begin
      if (be[0]) mem[addr_p0[AW+1:2]][7:0]   <= wlane[7:0];
      if (be[1]) mem[addr_p0[AW+1:2]][15:8]  <= wlane[15:8];
      if (be[2]) mem[addr_p0[AW+1:2]][23:16] <= wlane[23:16];
      if (be[3]) mem[addr_p0[AW+1:2]][31:24] <= wlane[31:24];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      is_store_p0 <= 1'b0;
      rdata       <= 32'd0;
      rvalid      <= 1'b0;
      acc_err     <= 1'b0;
    end else begin
      rvalid  <= 1'b0;
      acc_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (legal) begin
              is_store_p0 <= memw;
              if (WAIT_CYCLES == 0) begin
                state <= ST_RESP;
              end else begin
                state <= ST_WAIT;
                cnt   <= WAIT_INIT;
              end
            end else begin
              acc_err <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: begin
          state <= ST_IDLE;
          if (!is_store_p0) begin
            rdata  <= load_ext(word_rd, addr_p0[1:0], funct3_p0);
            rvalid <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_CYCLES=1 and 0) checked every
// cycle against a transaction-level model of the responder, plus directed
// accesses with hand-computed expected load data.
module tb_dmem_responder;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memr_s    [2];
  logic        memw_s    [2];
  logic [2:0]  f3_s      [2];
  logic [31:0] addr_s    [2];
  logic [31:0] wdata_s   [2];
  logic        stall_s   [2];
  logic [31:0] rdata_s   [2];
  logic        rvalid_s  [2];
  logic        acc_err_s [2];

  int checks = 0;
  int fails  = 0;
  bit started = 1'b0;

  // Model state
  logic [31:0] mmem [int];
  int          mbusy [2] = '{0, 0};
  bit          mrv   [2] = '{0, 0};
  bit          merr  [2] = '{0, 0};
  logic [31:0] mrd   [2] = '{32'd0, 32'd0};
  bit          mq_w  [2];
  logic [2:0]  mq_f  [2];
  logic [31:0] mq_a  [2];
  logic [31:0] mq_wd [2];

  // Observation counters
  int          nrv     [2] = '{0, 0};
  int          nerr    [2] = '{0, 0};
  logic [31:0] last_rd [2] = '{32'd0, 32'd0};

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .memr(memr_s[0]), .memw(memw_s[0]),
    .funct3(f3_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]),
    .stall(stall_s[0]), .rdata(rdata_s[0]), .rvalid(rvalid_s[0]),
    .acc_err(acc_err_s[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .memr(memr_s[1]), .memw(memw_s[1]),
    .funct3(f3_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]),
    .stall(stall_s[1]), .rdata(rdata_s[1]), .rvalid(rvalid_s[1]),
    .acc_err(acc_err_s[1])
  );

  function automatic int wc(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, got, exp);
    end
  endtask

  function automatic bit m_legal(input bit w, input logic [2:0] f, input logic [31:0] a);
    longint ua;
    int     n;
    bit     fok;
    ua  = a;
    fok = w ? (f <= 3'd2) : (f <= 3'd2 || f == 3'd4 || f == 3'd5);
    if (!fok) return 1'b0;
    n = 1 << f[1:0];
    if ((ua % n) != 0) return 1'b0;
    if ((ua / 4) >= DEPTH) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_store(input int d, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] wd);
    int n;
    longint ba;
    int key;
    logic [31:0] word;
    n = 1 << f[1:0];
    for (int k = 0; k < n; k++) begin
      ba  = longint'(a) + k;
      key = d * 4096 + int'(ba / 4);
      word = mmem[key];
      word[8*int'(ba % 4) +: 8] = wd[8*k +: 8];
      mmem[key] = word;
    end
  endtask

  function automatic logic [31:0] m_load(input int d, input logic [2:0] f, input logic [31:0] a);
    int n;
    longint ba;
    logic [31:0] word;
    logic [31:0] v;
    n = 1 << f[1:0];
    v = 32'd0;
    for (int k = 0; k < n; k++) begin
      ba   = longint'(a) + k;
      word = mmem[d * 4096 + int'(ba / 4)];
      v[8*k +: 8] = word[8*int'(ba % 4) +: 8];
    end
    if (!f[2] && n < 4)
      for (int j = 8 * n; j < 32; j++) v[j] = v[8*n-1];
    return v;
  endfunction

  // Transaction-level model: mbusy counts cycles to the completion cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        mbusy[d] <= 0;
        mrv[d]   <= 1'b0;
        merr[d]  <= 1'b0;
        mrd[d]   <= 32'd0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        mrv[d]  <= 1'b0;
        merr[d] <= 1'b0;
        if (mbusy[d] == 1) begin
          if (mq_w[d]) m_store(d, mq_f[d], mq_a[d], mq_wd[d]);
          else begin
            mrd[d] <= m_load(d, mq_f[d], mq_a[d]);
            mrv[d] <= 1'b1;
          end
          mbusy[d] <= 0;
        end else if (mbusy[d] > 1) begin
          mbusy[d] <= mbusy[d] - 1;
        end else if (memr_s[d] || memw_s[d]) begin
          if (m_legal(memw_s[d], f3_s[d], addr_s[d])) begin
            mq_w[d]  <= memw_s[d];
            mq_f[d]  <= f3_s[d];
            mq_a[d]  <= addr_s[d];
            mq_wd[d] <= wdata_s[d];
            mbusy[d] <= wc(d) + 1;
          end else begin
            merr[d] <= 1'b1;
          end
        end
      end
    end
  end

  // Compare process, sampled on the falling edge
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic exp_st;
      if (started) begin
        exp_st = rst_n && (mbusy[d] >= 2 ||
                 (mbusy[d] == 0 && (memr_s[d] || memw_s[d]) &&
                  m_legal(memw_s[d], f3_s[d], addr_s[d])));
        chk($sformatf("stall%0d", d),   32'(stall_s[d]),   32'(exp_st));
        chk($sformatf("rvalid%0d", d),  32'(rvalid_s[d]),  32'(mrv[d]));
        chk($sformatf("acc_err%0d", d), 32'(acc_err_s[d]), 32'(merr[d]));
        chk($sformatf("rdata%0d", d),   rdata_s[d],        mrd[d]);
      end
      if (rvalid_s[d] === 1'b1) begin
        nrv[d]++;
        last_rd[d] = rdata_s[d];
      end
      if (acc_err_s[d] === 1'b1) nerr[d]++;
    end
  end

  task automatic idle(input int d, input int n);
    memr_s[d] = 1'b0;
    memw_s[d] = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a request (called just after a rising edge) and holds it until
  // stall is seen low; returns after the edge that ends the request.
  task automatic access(input int d, input bit r, input bit w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] wd, input bit scramble,
                        output int sc);
    memr_s[d] = r; memw_s[d] = w; f3_s[d] = f; addr_s[d] = a; wdata_s[d] = wd;
    sc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall_s[d]) begin
        @(posedge clk);
        #1;
        return;
      end
      sc++;
      @(posedge clk);
      #1;
      if (scramble) begin
        addr_s[d] = $urandom; wdata_s[d] = $urandom; f3_s[d] = 3'($urandom_range(0, 7));
      end
    end
    checks++;
    fails++;
    $display("FAIL stall_timeout dut%0d actual=stuck_high required=low_within_40", d);
  endtask

  task automatic do_op(input int d, input bit r, input bit w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] wd, input string nm,
                       input int esc);
    int sc;
    access(d, r, w, f, a, wd, 1'b0, sc);
    chk({nm, "_stall_cycles"}, 32'(sc), 32'(esc));
    idle(d, 1);
  endtask

  task automatic do_ld(input int d, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] exp, input string nm);
    do_op(d, 1'b1, 1'b0, f, a, 32'd0, nm, wc(d) + 1);
    chk(nm, last_rd[d], exp);
  endtask

  int          e0, v0, sc, sel, kind;
  logic [31:0] ra;
  bit          rr, rw;

  initial begin
    for (int d = 0; d < 2; d++) begin
      memr_s[d] = 1'b0; memw_s[d] = 1'b0; f3_s[d] = 3'd0;
      addr_s[d] = 32'd0; wdata_s[d] = 32'd0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_stall",   32'(stall_s[d]),   32'd0);
      chk("reset_rvalid",  32'(rvalid_s[d]),  32'd0);
      chk("reset_acc_err", 32'(acc_err_s[d]), 32'd0);
      chk("reset_rdata",   rdata_s[d],        32'd0);
    end
    started = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known contents for every word the run touches
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++)
        do_op(d, 1'b0, 1'b1, 3'd2, 32'(i * 4), 32'h1000_0000 + 32'(i), "init_sw", wc(d) + 1);
      do_op(d, 1'b0, 1'b1, 3'd2, 32'hFC, 32'h1000_003F, "init_sw63", wc(d) + 1);
    end

    // Word store then load
    v0 = nrv[0];
    do_op(0, 1'b0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, "sw_10", 2);
    do_ld(0, 3'd2, 32'h10, 32'hDEAD_BEEF, "lw_10");
    chk("lw_10_rvalid_pulses", 32'(nrv[0] - v0), 32'd1);

    // Byte store and signed/unsigned byte loads
    do_op(0, 1'b0, 1'b1, 3'd2, 32'h10, 32'h0, "sw_10_zero", 2);
    do_op(0, 1'b0, 1'b1, 3'd0, 32'h13, 32'h80, "sb_13", 2);
    do_ld(0, 3'd0, 32'h13, 32'hFFFF_FF80, "lb_13");
    do_ld(0, 3'd4, 32'h13, 32'h0000_0080, "lbu_13");
    do_ld(0, 3'd2, 32'h10, 32'h8000_0000, "lw_10_after_sb");

    // Misaligned requests
    e0 = nerr[0];
    do_op(0, 1'b1, 1'b0, 3'd1, 32'h11, 32'h0, "lh_11_misaligned", 0);
    chk("lh_11_err_pulses", 32'(nerr[0] - e0), 32'd1);
    do_op(0, 1'b0, 1'b1, 3'd2, 32'h22, 32'h5555_5555, "sw_22_misaligned", 0);
    chk("sw_22_err_pulses", 32'(nerr[0] - e0), 32'd2);
    do_ld(0, 3'd2, 32'h20, 32'h1000_0008, "lw_20_unchanged");

    // Zero wait states, back-to-back store then load
    access(1, 1'b0, 1'b1, 3'd2, 32'h4, 32'hCAFE_F00D, 1'b0, sc);
    chk("b2b_sw_stall_cycles", 32'(sc), 32'd1);
    access(1, 1'b1, 1'b0, 3'd2, 32'h4, 32'h0, 1'b0, sc);
    chk("b2b_lw_stall_cycles", 32'(sc), 32'd1);
    idle(1, 1);
    chk("b2b_lw_data", last_rd[1], 32'hCAFE_F00D);

    // Reset during the wait state of a store
    v0 = nrv[0];
    memw_s[0] = 1'b1; f3_s[0] = 3'd2; addr_s[0] = 32'h10; wdata_s[0] = 32'h1234_5678;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    memw_s[0] = 1'b0;
    #1;
    chk("rst_mid_stall",  32'(stall_s[0]),  32'd0);
    chk("rst_mid_rvalid", 32'(rvalid_s[0]), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(0, 1);
    chk("rst_mid_no_rvalid", 32'(nrv[0] - v0), 32'd0);
    do_ld(0, 3'd2, 32'h10, 32'h8000_0000, "lw_10_after_rst");

    // Both strobes: illegal funct3, out of range, then legal
    e0 = nerr[0];
    do_op(0, 1'b1, 1'b1, 3'd3, 32'h10, 32'hFFFF_FFFF, "both_f3_011", 0);
    do_op(0, 1'b0, 1'b1, 3'd2, 32'(DEPTH * 4), 32'hFFFF_FFFF, "sw_out_of_range", 0);
    do_op(0, 1'b1, 1'b0, 3'd2, 32'h100, 32'h0, "lw_out_of_range", 0);
    chk("illegal_err_pulses", 32'(nerr[0] - e0), 32'd3);
    do_ld(0, 3'd2, 32'h10, 32'h8000_0000, "lw_10_after_illegal");
    v0 = nrv[0];
    do_op(0, 1'b1, 1'b1, 3'd2, 32'h14, 32'h55AA_55AA, "both_legal", 2);
    idle(0, 1);
    chk("both_legal_no_rvalid", 32'(nrv[0] - v0), 32'd0);
    do_ld(0, 3'd2, 32'h14, 32'h55AA_55AA, "lw_14_after_both");

    // Last legal word, upper halfword
    do_op(0, 1'b0, 1'b1, 3'd1, 32'hFE, 32'h0000_9ABC, "sh_fe", 2);
    do_ld(0, 3'd1, 32'hFE, 32'hFFFF_9ABC, "lh_fe");
    do_ld(0, 3'd5, 32'hFE, 32'h0000_9ABC, "lhu_fe");
    do_ld(0, 3'd2, 32'hFC, 32'h9ABC_003F, "lw_fc");

    // Randomised traffic on both instances
    for (int d = 0; d < 2; d++) begin
      for (int it = 0; it < 250; it++) begin
        sel = $urandom_range(0, 9);
        if (sel < 7)       ra = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        else if (sel == 7) ra = 32'hFC | 32'($urandom_range(0, 3));
        else if (sel == 8) ra = 32'(DEPTH * 4 + $urandom_range(0, 400));
        else               ra = $urandom | 32'h8000_0000;
        kind = $urandom_range(0, 3);
        rr = (kind != 1);
        rw = (kind == 1 || kind == 2);
        access(d, rr, rw, 3'($urandom_range(0, 7)), ra, $urandom,
               1'($urandom_range(0, 1)), sc);
        if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 2));
      end
      idle(d, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=no_finish required=finish_before_500000");
    $fatal(1, "watchdog expired");
  end

endmodule
